arrow_game_core: RTL and testbench

//  N-player Arrowspace game engine. Holds one shared key sequence per level and a per-player match tracker.

---
 rtl/arrow_game_pkg.sv | 42 ++++
 rtl/arrow_game_if.sv | 23 ++
 rtl/arrow_game_core_player_match.sv | 85 ++++++++
 rtl/arrow_game_core.sv | 165 ++++++++++++++++
 tb/tb_arrow_game_core.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arrow_game_pkg.sv
// Shared types and constants for the Arrowspace game engine.
// No logic: enum, opcodes, arrow codes, LFSR seed/taps and helpers.
// No flow control; consumers are purely combinational users of these items.
package arrow_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_LEVEL_END = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_t;

    // Upper opcode nibble selecting the reply layout.
    localparam logic [3:0] OP_LEVEL = 4'h1;
    localparam logic [3:0] OP_MATCH = 4'h2;

    // One-hot arrow key codes, indexed by direction 0..3.
    localparam logic [3:0] ARROW_UP    = 4'b0001;
    localparam logic [3:0] ARROW_DOWN  = 4'b0010;
    localparam logic [3:0] ARROW_LEFT  = 4'b0100;
    localparam logic [3:0] ARROW_RIGHT = 4'b1000;

    // Fibonacci LFSR, taps at bits 16,14,13,11 (1-based).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [3:0] arrow_code(input logic [1:0] dir);
        logic [3:0] code;
        case (dir)
            2'd0:    code = ARROW_UP;
            2'd1:    code = ARROW_DOWN;
            2'd2:    code = ARROW_LEFT;
            default: code = ARROW_RIGHT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/arrow_game_if.sv
// Player key strobes plus the SPI opcode/reply pair of the game engine.
// Combinational bundle, no latency of its own.
// No backpressure: key strobes and pulse_load are single-cycle events.
interface arrow_game_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int KEY_W       = 4
);
    logic [NUM_PLAYERS-1:0]       key_valid;
    logic [NUM_PLAYERS*KEY_W-1:0] key_code;
    logic [7:0]                   activeopcode;
    logic                         pulse_load;
    logic [23:0]                  reply;

    modport master (
        output key_valid, key_code, activeopcode, pulse_load,
        input  reply
    );

    modport slave (
        input  key_valid, key_code, activeopcode, pulse_load,
        output reply
    );
endinterface

// File: rtl/arrow_game_core_player_match.sv
// One player's match tracker: index, done, sticky flags, score and lives.
// Key strobe takes effect on the next clock edge.
// No backpressure: a strobe is consumed or ignored (dead, done, not playing).
module player_match #(
    parameter int SEQ_LEN = 4,
    parameter int KEY_W   = 4,
    parameter int LIVES   = 7,
    parameter int LIFE_W  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     play,
    input  logic                     init,
    input  logic                     level_end,
    input  logic                     key_valid,
    input  logic [KEY_W-1:0]         key_code,
    input  logic [SEQ_LEN*KEY_W-1:0] key_seq,
    input  logic                     pulse_load,
    output logic [LIFE_W-1:0]        lives,
    output logic                     alive,
    output logic                     done,
    output logic                     correct,
    output logic                     wrong,
    output logic [7:0]               score,
    output logic                     will_die
);
    localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    logic [IDX_W-1:0] idx;
    logic             take;
    logic             hit;
    logic             last;

    assign alive    = (lives != '0);
    assign take     = play && alive && !done && key_valid;
    assign hit      = (key_code == key_seq[idx*KEY_W +: KEY_W]);
    assign last     = (idx == IDX_W'(SEQ_LEN - 1));
    // This player's last life goes at the coming level end.
    assign will_die = alive && !done && (lives == LIFE_W'(1));

    // Progress through the sequence, level-end penalty and game restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lives <= LIFE_W'(LIVES);
            idx   <= '0;
            done  <= 1'b0;
            score <= 8'd0;
        end else if (init) begin
            lives <= LIFE_W'(LIVES);
            idx   <= '0;
            done  <= 1'b0;
            score <= 8'd0;
        end else if (level_end) begin
            if (alive && !done) begin
                lives <= lives - 1'b1;
            end
            idx  <= '0;
            done <= 1'b0;
        end else if (take) begin
            if (hit) begin
                if (last) begin
                    done  <= 1'b1;
                    score <= score + 8'd1;
                    idx   <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                idx <= '0;
            end
        end
    end

    // Sticky flags: a new event in the same cycle as pulse_load survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            correct <= 1'b0;
            wrong   <= 1'b0;
        end else begin
            correct <= (take && hit)  || (correct && !pulse_load);
            wrong   <= (take && !hit) || (wrong   && !pulse_load);
        end
    end

endmodule

// File: rtl/arrow_game_core.sv
// Arrowspace game engine: shared level sequence, level timer, per-player trackers, SPI reply.
// Reply is combinational on activeopcode; state changes one clock after start/expiry/key strobe.
// No backpressure; optional macro GAME_SPEEDUP_EN halves the level length per level.
module arrow_game_core
    import arrow_game_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int SEQ_LEN     = 4,
    parameter int KEY_W       = 4,
    parameter int TIMER_W     = 28,
    parameter int LIVES       = 7,
    parameter int LIFE_W      = 3,
    parameter int LEVEL_W     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    arrow_game_if.slave                   bus,
    output logic [SEQ_LEN*KEY_W-1:0]      key_seq,
    output logic [LEVEL_W-1:0]            level,
    output logic [NUM_PLAYERS*LIFE_W-1:0] lives,
    output logic [NUM_PLAYERS-1:0]        alive,
    output logic                          game_over
);
    game_state_t                     state;
    logic [15:0]                     lfsr;
    logic [TIMER_W-1:0]              timer;
    logic [TIMER_W-1:0]              timer_limit;
    logic [SEQ_LEN*KEY_W-1:0]        next_seq;
    logic [NUM_PLAYERS-1:0]          will_die;
    logic [NUM_PLAYERS-1:0]          done;
    logic [NUM_PLAYERS-1:0]          correct;
    logic [NUM_PLAYERS-1:0]          wrong;
    logic [NUM_PLAYERS-1:0][7:0]     score;
    logic                            start_go;
    logic                            in_play;
    logic                            in_level_end;
    logic                            survivors;
    logic                            sel_ok;
    logic [LIFE_W-1:0]               sel_lives;
    logic [2:0]                      sel_flags;
    logic [7:0]                      sel_score;
    logic [23:0]                     reply_dat;

    assign start_go     = start && (state == ST_IDLE || state == ST_GAME_OVER);
    assign in_play      = (state == ST_PLAY);
    assign in_level_end = (state == ST_LEVEL_END);
    assign survivors    = |(alive & ~will_die);

    // Level length, optionally shrinking by half each level.
    always_comb begin
`ifdef GAME_SPEEDUP_EN
        timer_limit = {TIMER_W{1'b1}} >> level;
`else
        timer_limit = {TIMER_W{1'b1}};
`endif
    end

    // Candidate sequence from the free-running LFSR, one arrow per key slot.
    always_comb begin
        next_seq = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            next_seq[i*KEY_W +: KEY_W] = KEY_W'(arrow_code(lfsr[(i*KEY_W) % 16 +: 2]));
        end
    end

    // Top-level game FSM with registered sequence, level and game_over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            lfsr      <= LFSR_SEED;
            timer     <= '0;
            level     <= '0;
            key_seq   <= '0;
            game_over <= 1'b0;
        end else begin
            lfsr <= lfsr_step(lfsr);
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start) begin
                        state     <= ST_PLAY;
                        timer     <= '0;
                        level     <= '0;
                        key_seq   <= next_seq;
                        game_over <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (timer == timer_limit) begin
                        state <= ST_LEVEL_END;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_LEVEL_END: begin
                    timer   <= '0;
                    key_seq <= next_seq;
                    if (level != {LEVEL_W{1'b1}}) begin
                        level <= level + 1'b1;
                    end
                    if (survivors) begin
                        state <= ST_PLAY;
                    end else begin
                        state     <= ST_GAME_OVER;
                        game_over <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        player_match #(
            .SEQ_LEN (SEQ_LEN),
            .KEY_W   (KEY_W),
            .LIVES   (LIVES),
            .LIFE_W  (LIFE_W)
        ) u_player (
            .clk        (clk),
            .reset      (reset),
            .play       (in_play),
            .init       (start_go),
            .level_end  (in_level_end),
            .key_valid  (bus.key_valid[g]),
            .key_code   (bus.key_code[g*KEY_W +: KEY_W]),
            .key_seq    (key_seq),
            .pulse_load (bus.pulse_load),
            .lives      (lives[g*LIFE_W +: LIFE_W]),
            .alive      (alive[g]),
            .done       (done[g]),
            .correct    (correct[g]),
            .wrong      (wrong[g]),
            .score      (score[g]),
            .will_die   (will_die[g])
        );
    end

    // SPI reply for the player in opcode bits [1:0]; absent players read as zero.
    always_comb begin
        sel_ok    = 1'b0;
        sel_lives = '0;
        sel_flags = 3'b000;
        sel_score = 8'd0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (bus.activeopcode[1:0] == 2'(i)) begin
                sel_ok    = 1'b1;
                sel_lives = lives[i*LIFE_W +: LIFE_W];
                sel_flags = {correct[i], wrong[i], done[i]};
                sel_score = score[i];
            end
        end
        reply_dat = 24'h0;
        if (sel_ok) begin
            case (bus.activeopcode[7:4])
                OP_LEVEL: reply_dat = {game_over, 3'(sel_lives), 2'b00, 2'(level), 16'(key_seq)};
                OP_MATCH: reply_dat = {sel_flags, 13'b0, sel_score};
                default:  reply_dat = 24'h0;
            endcase
        end
    end

    assign bus.reply = reply_dat;

endmodule

// File: tb/tb_arrow_game_core.sv
// Scoreboard bench for arrow_game_core: stimulus pushes expectations, a monitor pops and compares.
// Small timer (TIMER_W=6) keeps levels short; an LFSR model predicts each new sequence.
// Covers play, sticky flags, level end, saturation, game over, restart and async reset.
`timescale 1ns/1ps
module tb_arrow_game_core;
    localparam int NP  = 2;
    localparam int SL  = 4;
    localparam int KW  = 4;
    localparam int TW  = 6;
    localparam int LV  = 7;
    localparam int LW  = 3;
    localparam int LVW = 2;

    localparam int K_REPLY = 0;
    localparam int K_SEQ   = 1;
    localparam int K_LEVEL = 2;
    localparam int K_LIVES = 3;
    localparam int K_ALIVE = 4;
    localparam int K_GO    = 5;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [SL*KW-1:0]     key_seq;
    logic [LVW-1:0]       level;
    logic [NP*LW-1:0]     lives;
    logic [NP-1:0]        alive;
    logic                 game_over;

    arrow_game_if #(.NUM_PLAYERS(NP), .KEY_W(KW)) bus();

    arrow_game_core #(
        .NUM_PLAYERS(NP), .SEQ_LEN(SL), .KEY_W(KW), .TIMER_W(TW),
        .LIVES(LV), .LIFE_W(LW), .LEVEL_W(LVW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .key_seq   (key_seq),
        .level     (level),
        .lives     (lives),
        .alive     (alive),
        .game_over (game_over)
    );

    always #50 clk = ~clk;

    // Reference LFSR stepping alongside the design.
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [15:0] seq_of(input logic [15:0] s);
        logic [15:0] r;
        logic [1:0]  d;
        r = 16'h0;
        for (int i = 0; i < 4; i++) begin
            d = s[i*4 +: 2];
            r[i*4 +: 4] = 4'b0001 << d;
        end
        return r;
    endfunction

    typedef struct {
        string       name;
        int          kind;
        logic [23:0] exp;
    } chk_t;

    chk_t        sb_q[$];
    event        probe;
    int          checks = 0;
    int          errors = 0;
    int          since  = 0;
    logic [1:0]  e_level;

    function automatic int lim();
`ifdef GAME_SPEEDUP_EN
        return 63 >> e_level;
`else
        return 63;
`endif
    endfunction

    task automatic sb_push(input string name, input int kind, input logic [23:0] exp);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.exp  = exp;
        sb_q.push_back(c);
        -> probe;
        #2;
    endtask

    task automatic chk_reply(input string name, input logic [7:0] op, input logic [23:0] exp);
        bus.activeopcode = op;
        sb_push(name, K_REPLY, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            since++;
        end
    endtask

    task automatic press(input int p, input logic [3:0] code);
        bus.key_valid = '0;
        bus.key_valid[p] = 1'b1;
        bus.key_code[p*4 +: 4] = code;
        tick(1);
        bus.key_valid = '0;
    endtask

    task automatic do_start(output logic [15:0] s);
        start = 1'b1;
        s = seq_of(m_lfsr);
        tick(1);
        start = 1'b0;
        since = 0;
    endtask

    // Advance to the LEVEL_END edge; returns the sequence loaded there.
    task automatic finish_level(output logic [15:0] nseq);
        int target;
        target = lim() + 1;
        checks++;
        if (since > target) begin
            errors++;
            $display("FAIL level_timing: elapsed %0d beyond expiry point %0d", since, target);
        end else begin
            tick(target - since);
        end
        nseq = seq_of(m_lfsr);
        tick(1);
        since = 0;
    endtask

    task automatic chk_state(input string tag, input logic [15:0] s, input logic [2:0] l1,
                             input logic [2:0] l0, input logic go);
        sb_push({tag, "_keyseq"}, K_SEQ, {8'h0, s});
        sb_push({tag, "_level"},  K_LEVEL, {22'h0, e_level});
        sb_push({tag, "_lives"},  K_LIVES, {18'h0, l1, l0});
        sb_push({tag, "_alive"},  K_ALIVE, {22'h0, (l1 != 3'd0), (l0 != 3'd0)});
        sb_push({tag, "_gameover"}, K_GO,  {23'h0, go});
    endtask

    // Monitor: drains the scoreboard whenever stimulus raises a probe.
    initial begin : monitor
        chk_t        c;
        logic [23:0] act;
        forever begin
            @(probe);
            #1;
            while (sb_q.size() > 0) begin
                c = sb_q.pop_front();
                case (c.kind)
                    K_REPLY: act = bus.reply;
                    K_SEQ:   act = {8'h0, key_seq};
                    K_LEVEL: act = {22'h0, level};
                    K_LIVES: act = {18'h0, lives};
                    K_ALIVE: act = {22'h0, alive};
                    default: act = {23'h0, game_over};
                endcase
                checks++;
                if (act !== c.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #(100 * 20000);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] seq;
        logic [15:0] ns;
        logic [2:0]  e_l0;
        logic [2:0]  e_l1;

        bus.key_valid    = '0;
        bus.key_code     = '0;
        bus.activeopcode = 8'h00;
        bus.pulse_load   = 1'b0;
        e_level = 2'd0;
        e_l0 = 3'd7;
        e_l1 = 3'd7;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_state("reset", 16'h0, 3'd7, 3'd7, 1'b0);
        chk_reply("reset_op10", 8'h10, 24'h700000);
        chk_reply("reset_op20", 8'h20, 24'h000000);

        // 1: P0 completes the sequence
        do_start(seq);
        chk_state("start", seq, 3'd7, 3'd7, 1'b0);
        for (int i = 0; i < 4; i++) press(0, seq[i*4 +: 4]);
        chk_reply("p0_done", 8'h20, 24'hA00001);
        chk_reply("p1_idle", 8'h21, 24'h000000);
        chk_reply("op_other", 8'h30, 24'h000000);

        // 2: P1 right then wrong key, flag clearing and set-wins
        press(1, seq[7:4] ^ 4'hF);
        chk_reply("p1_wrong_first", 8'h21, 24'h400000);
        bus.pulse_load = 1'b1;
        tick(1);
        bus.pulse_load = 1'b0;
        press(1, seq[3:0]);
        press(1, seq[7:4] ^ 4'hF);
        chk_reply("p1_right_wrong", 8'h21, 24'hC00000);
        bus.pulse_load = 1'b1;
        tick(1);
        bus.pulse_load = 1'b0;
        chk_reply("p1_cleared", 8'h21, 24'h000000);
        chk_reply("p0_cleared", 8'h20, 24'h200001);
        bus.pulse_load = 1'b1;
        press(1, seq[3:0] ^ 4'hF);
        bus.pulse_load = 1'b0;
        chk_reply("p1_set_wins", 8'h21, 24'h400000);
        bus.pulse_load = 1'b1;
        tick(1);
        bus.pulse_load = 1'b0;
        press(1, seq[3:0]);
        chk_reply("p1_idx_reset", 8'h21, 24'h800000);
        press(0, seq[3:0]);
        chk_reply("p0_done_ignores", 8'h20, 24'h200001);

        // 3: first level end, P0 done and P1 not
        finish_level(ns);
        e_level = 2'd1;
        e_l1 = 3'd6;
        chk_state("lvl1", ns, e_l1, e_l0, 1'b0);
        chk_reply("lvl1_p0", 8'h20, 24'h000001);
        chk_reply("lvl1_p1", 8'h21, 24'h800000);
        chk_reply("lvl1_op10", 8'h10, {8'h71, ns});

        // 4/5: idle levels until everyone is out; level saturates at 3
        for (int k = 0; k < 7; k++) begin
            finish_level(ns);
            if (e_level != 2'd3) e_level = e_level + 2'd1;
            if (e_l0 != 3'd0) e_l0 = e_l0 - 3'd1;
            if (e_l1 != 3'd0) e_l1 = e_l1 - 3'd1;
            chk_state($sformatf("idle_lvl%0d", k), ns, e_l1, e_l0, (k == 6));
        end
        press(0, ns[3:0]);
        chk_reply("over_key_ignored", 8'h20, 24'h000001);
        chk_reply("over_op10", 8'h10, {8'h83, ns});
        tick(5);
        chk_reply("over_stays", 8'h10, {8'h83, ns});

        // Restart from GAME_OVER
        do_start(seq);
        e_level = 2'd0;
        chk_state("restart", seq, 3'd7, 3'd7, 1'b0);
        chk_reply("restart_p0", 8'h20, 24'h000000);

        // 6: async reset mid-play
        press(0, seq[3:0]);
        chk_reply("replay_p0", 8'h20, 24'h800000);
        reset = 1'b1;
        tick(1);
        chk_state("midreset", 16'h0, 3'd7, 3'd7, 1'b0);
        chk_reply("midreset_p0", 8'h20, 24'h000000);
        chk_reply("midreset_op13", 8'h13, 24'h000000);
        chk_reply("midreset_op10", 8'h10, 24'h700000);
        reset = 1'b0;
        press(0, 4'b0001);
        chk_reply("idle_key_ignored", 8'h20, 24'h000000);
        chk_reply("absent_player", 8'h13, 24'h000000);

        #10;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
